// File: rtl/enemy_formation_ctrl.sv
// Purpose : marches the 7-enemy row (shared posX/posY offset, alive mask), reverses and drops at edges, flags cleared/landed.
// Latency : march moves visible 1 cycle after the step tick; drops visible 2 cycles after the step tick.
// Backpressure: none; frame_tick/kill_valid/start are single-cycle strobes. Optional macro SPEEDUP_EN shortens the march interval as enemies die.
module enemy_formation_ctrl #(
`ifdef SPEEDUP_EN
  parameter int MIN_INTERVAL  = 4,
  parameter int SPEEDUP_DEC   = 4,
`endif
  parameter int START_X       = 0,
  parameter int STEP_X        = 4,
  parameter int DROP_Y        = 8,
  parameter int BASE_INTERVAL = 30,
  parameter int LEFT_LIMIT    = 8,
  parameter int RIGHT_LIMIT   = 631,
  parameter int BOTTOM_LIMIT  = 471
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       kill_valid,
  input  logic [2:0] kill_idx,
  output logic [9:0] posX,
  output logic [9:0] posY,
  output logic [6:0] alive,
  output logic       dir,
  output logic       step_pulse,
  output logic       busy,
  output logic       cleared,
  output logic       landed
);

  typedef enum logic [2:0] {S_IDLE, S_MARCH, S_DROP, S_CLEARED, S_LANDED} state_t;

  // Edge arithmetic is done in 11 bits so sums of offsets never wrap.
  localparam logic [10:0] STEP11    = 11'(STEP_X);
  localparam logic [10:0] RIGHT_OFF = 11'(31 + 8 + STEP_X);  // centre base + half-size + next step
  localparam logic [10:0] RIGHT11   = 11'(RIGHT_LIMIT);
  localparam logic [10:0] LEFT11    = 11'(LEFT_LIMIT);
  localparam logic [10:0] BOTTOM11  = 11'(BOTTOM_LIMIT);
  localparam logic [9:0]  STEP10    = 10'(STEP_X);
  localparam logic [9:0]  DROP10    = 10'(DROP_Y);
  localparam logic [9:0]  START10   = 10'(START_X);

  state_t      state;
  logic [15:0] tick_cnt;
  logic [15:0] interval;
  logic [2:0]  lo_idx;
  logic [2:0]  hi_idx;
  logic [6:0]  kill_mask;
  logic [6:0]  alive_after;
  logic        kill_ok;
  logic        can_right;
  logic        can_left;
  logic        will_land;
  logic [10:0] posx11;
  logic [10:0] left_edge;
  logic [9:0]  new_posy;

`ifdef SPEEDUP_EN
  logic [3:0] pop;
  int         iv;

  // March interval shrinks by SPEEDUP_DEC per dead enemy, floored at MIN_INTERVAL.
  always_comb begin
    pop = '0;
    for (int i = 0; i < 7; i++) pop = pop + {3'd0, alive[i]};
    iv = BASE_INTERVAL - SPEEDUP_DEC * (7 - int'(pop));
    if (iv < MIN_INTERVAL) iv = MIN_INTERVAL;
    interval = 16'(iv);
  end
`else
  assign interval = 16'(BASE_INTERVAL);
`endif

  // Lowest and highest surviving enemy decide which sprite touches each edge.
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    for (int i = 6; i >= 0; i--) if (alive[i]) lo_idx = 3'(i);
    for (int i = 0; i < 7; i++)  if (alive[i]) hi_idx = 3'(i);
  end

  // Kill filtering, edge tests and landing test for the current cycle.
  always_comb begin
    kill_ok     = kill_valid && (kill_idx != 3'd7) && (state == S_MARCH || state == S_DROP);
    kill_mask   = kill_ok ? 7'(8'd1 << kill_idx) : 7'd0;
    alive_after = alive & ~kill_mask;
    posx11      = {1'b0, posX};
    can_right   = (RIGHT_OFF + ({8'd0, hi_idx} * 11'd24) + posx11) <= RIGHT11;
    // Leftmost sprite pixel after the step: 31 - 8 + 24*L + posX - STEP_X.
    left_edge   = 11'd23 + ({8'd0, lo_idx} * 11'd24) + posx11 - STEP11;
    can_left    = (posx11 >= STEP11) && (left_edge >= LEFT11);
    new_posy    = posY + DROP10;
    will_land   = (11'd247 + {1'b0, new_posy}) >= BOTTOM11;
  end

  // Sequencer: state, offsets, alive mask, flags and the step strobe, all registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      posX       <= START10;
      posY       <= '0;
      alive      <= 7'h7F;
      dir        <= 1'b1;
      tick_cnt   <= '0;
      step_pulse <= 1'b0;
      busy       <= 1'b0;
      cleared    <= 1'b0;
      landed     <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      alive      <= alive_after;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_MARCH;
            tick_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        S_MARCH: begin
          if (alive_after == 7'd0) begin
            state   <= S_CLEARED;
            busy    <= 1'b0;
            cleared <= 1'b1;
          end else if (frame_tick) begin
            if (tick_cnt >= interval - 16'd1) begin
              tick_cnt <= '0;
              // Edge test uses the pre-kill mask held in 'alive'.
              if (dir ? can_right : can_left) begin
                posX       <= dir ? posX + STEP10 : posX - STEP10;
                step_pulse <= 1'b1;
              end else begin
                state <= S_DROP;
              end
            end else begin
              tick_cnt <= tick_cnt + 16'd1;
            end
          end
        end
        S_DROP: begin
          if (alive_after == 7'd0) begin
            state   <= S_CLEARED;
            busy    <= 1'b0;
            cleared <= 1'b1;
          end else begin
            posY       <= new_posy;
            dir        <= ~dir;
            step_pulse <= 1'b1;
            if (will_land) begin
              state  <= S_LANDED;
              busy   <= 1'b0;
              landed <= 1'b1;
            end else begin
              state <= S_MARCH;
            end
          end
        end
        S_CLEARED, S_LANDED: begin
          if (start) begin
            state    <= S_MARCH;
            posX     <= START10;
            posY     <= '0;
            alive    <= 7'h7F;
            dir      <= 1'b1;
            tick_cnt <= '0;
            busy     <= 1'b1;
            cleared  <= 1'b0;
            landed   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
